matrix_shift_receiver: RTL and testbench
========================================

Name: matrix_shift_receiver

Overview:
- Receiving end of the 8x8 RGB LED-matrix serial link: the same shift-register protocol the matrix driver emits (shcp/stcp/ds/mr/oe plus one-hot row select).
- Oversamples the link on the system clock, rebuilds each 24-bit row word (8 red, 8 green, 8 blue), and assembles complete 8-row frames.
- Used as a second-board display slave, or as a bench monitor that checks the driver's frame against the game's board array.

Parameters:
CHAIN_BITS, 24, bits per latched row word
ROWS, 8, rows per frame
SYNC_STAGES, 2, synchronizer flops on every link input (minimum 2)

Ports:
clk  in  1  system clock; link edges are at least 4 clk periods apart
reset  in  1  synchronous, active-high
shcp  in  1  shift clock; ds is sampled on its rising edge
stcp  in  1  storage clock; its rising edge latches the row
ds  in  1  serial data
mr_n  in  1  active-low shift-register clear
oe_n  in  1  active-low output enable
rows_in  in  ROWS  one-hot active-row select
row_data  out  CHAIN_BITS  last latched row word
row_idx  out  3  row index of row_data
row_strobe  out  1  one-cycle pulse when row_data/row_idx update
frame  out  ROWS*CHAIN_BITS  last complete frame; row r at bits [r*24+23 : r*24]
frame_valid  out  1  one-cycle pulse when frame updates
display_on  out  1  synchronized inverse of oe_n
len_err  out  1  sticky: latch with bit count not equal to CHAIN_BITS
row_err  out  1  sticky: latch with rows_in not one-hot
locked  out  1  high in ACTIVE state

Behaviour:
- Reset: all outputs 0, shift register 0, bit_cnt 0, row mask 0, working buffer 0, state HUNT. Reset overrides everything.
- Synchronization: all link inputs pass through SYNC_STAGES flops. ds and rows_in use the same depth as shcp/stcp, so they stay aligned.
- Edge detection: a rising edge is the synchronized value 1 with the previous registered value 0. Detection latency is SYNC_STAGES+1 clk from the pin edge.
- Shift, on a shcp rising edge: sreg <= {sreg[22:0], ds_s}. The first bit shifted in ends at bit 23. bit_cnt increments and saturates at 31.
- Clear: while mr_n_s is 0, sreg and bit_cnt are held at 0. Clear takes priority over shift.
- Latch, on a stcp rising edge: uses the values of sreg and bit_cnt from before this cycle's update. bit_cnt then resets to 0, or to 1 if a shcp edge occurs in the same cycle.
- Simultaneous shcp and stcp edges: the latch takes the old sreg and the shift still occurs (matches 74HC595 behaviour).
- FSM HUNT: shifting runs and latches are discarded. The first stcp edge sends the FSM to ACTIVE with no row written, which aligns to word boundaries.
- FSM ACTIVE, on each latch:
  - If bit_cnt != CHAIN_BITS: set len_err.
  - If rows_in_s is not one-hot: set row_err; no write, no strobe.
  - Otherwise: row_data <= old sreg; row_idx <= encoded row; row_strobe pulses; the working buffer row is written and its mask bit is set. A length error alone still writes.
- Frame completion: the cycle after a write that makes the mask all-ones, frame <= working buffer (atomic), frame_valid pulses, and the mask clears.
  - Rewriting a row before completion overwrites its data and leaves the mask unchanged.
  - frame holds its old value until the next completion.
- Row errors: 3 consecutive row_err latches return the FSM to HUNT and clear the mask; frame is retained.
- oe_n does not affect capture; it only drives display_on.
- Reset mid-word or mid-frame: partial data is lost and the FSM returns to HUNT.

Test Plan:
- Reset then a dummy latch (HUNT to ACTIVE), then shift 24 bits 0xFF00AA MSB-first with rows_in=8'h01 and latch → row_strobe once, row_data=24'hFF00AA, row_idx=0, no frame_valid, locked=1.
- Send rows 0..7 with word 24'h000001<<r → frame_valid one cycle after the row-7 strobe; frame row r = 1<<r; len_err=0, row_err=0.
- Shift 23 bits then latch → len_err=1 and the row is still written. Next word of 24 bits is accepted normally; len_err stays 1.
- rows_in=8'h03 at latch → row_err=1, no row_strobe. Three consecutive such latches → locked=0. The next dummy latch re-locks.
- mr_n pulsed low after 12 bits, then 24 bits 0x123456 and latch → row_data=24'h123456, len_err=0.
- Same-cycle shcp and stcp edges → row_data equals the pre-shift word; the following latch counts the coincident bit, so 23 further bits give a count of 24 and no len_err. Reset asserted after 4 rows → frame=0, locked=0.

Source files
------------

// File: rtl/matrix_shift_receiver.sv
// matrix_shift_receiver: receiver for the 8x8 RGB LED-matrix serial link
// Oversamples the driver's shift-register link on clk, rebuilds each latched
// 24-bit row word and assembles complete frames.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   shcp, stcp, ds    shift clock, storage clock, serial data (asynchronous)
//   mr_n, oe_n        active-low shift clear, active-low output enable
//   rows_in           one-hot active-row select
//   row_data, row_idx last latched row word and its row index
//   row_strobe        one-cycle pulse when row_data/row_idx update
//   frame             last complete frame, row r at [r*CHAIN_BITS +: CHAIN_BITS]
//   frame_valid       one-cycle pulse when frame updates
//   display_on        synchronized inverse of oe_n
//   len_err, row_err  sticky word-length / row-select errors
//   locked            receiver is word-aligned (ACTIVE)
module matrix_shift_receiver #(
    parameter int CHAIN_BITS  = 24,
    parameter int ROWS        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       shcp,
    input  logic                       stcp,
    input  logic                       ds,
    input  logic                       mr_n,
    input  logic                       oe_n,
    input  logic [ROWS-1:0]            rows_in,
    output logic [CHAIN_BITS-1:0]      row_data,
    output logic [2:0]                 row_idx,
    output logic                       row_strobe,
    output logic [ROWS*CHAIN_BITS-1:0] frame,
    output logic                       frame_valid,
    output logic                       display_on,
    output logic                       len_err,
    output logic                       row_err,
    output logic                       locked
);
    localparam int NIN = ROWS + 5;
    // mr_n and oe_n idle high so reset does not fake a clear or enable the display
    localparam logic [NIN-1:0] LP_SYNC_RST = {{ROWS{1'b0}}, 5'b11000};
    localparam logic [4:0]     LP_LEN      = 5'(CHAIN_BITS);
    typedef enum logic {ST_HUNT, ST_ACTIVE} state_t;
    state_t                      r_state, w_state_next;
    logic [NIN-1:0]              r_sync [SYNC_STAGES];
    logic [NIN-1:0]              w_s;
    logic                        r_shcp_d, r_stcp_d;
    logic                        w_shcp_rise, w_stcp_rise;
    logic [ROWS-1:0]             w_rows_s;
    logic                        w_row_ok;
    logic [2:0]                  w_row_enc;
    logic [CHAIN_BITS-1:0]       r_sreg;
    logic [4:0]                  r_bit_cnt;
    logic [ROWS*CHAIN_BITS-1:0]  r_buf;
    logic [ROWS-1:0]             r_mask, w_mask_next;
    logic [1:0]                  r_err_cnt;
    logic                        w_latch, w_write, w_row_bad, w_len_bad, w_complete;
    // all link inputs share one chain so ds/rows_in stay aligned with the clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= LP_SYNC_RST;
            r_shcp_d <= 1'b0;
            r_stcp_d <= 1'b0;
        end else begin
            r_sync[0] <= {rows_in, oe_n, mr_n, ds, stcp, shcp};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_shcp_d <= w_s[0];
            r_stcp_d <= w_s[1];
        end
    end
    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_shcp_rise = w_s[0] & ~r_shcp_d;
    assign w_stcp_rise = w_s[1] & ~r_stcp_d;
    assign w_rows_s    = w_s[NIN-1:5];
    assign w_row_ok    = (w_rows_s != '0) && ((w_rows_s & (w_rows_s - ROWS'(1))) == '0);
    always_comb begin
        w_row_enc = 3'd0;
        for (int i = 0; i < ROWS; i++) if (w_rows_s[i]) w_row_enc = 3'(i);
    end
    assign w_latch    = (r_state == ST_ACTIVE) && w_stcp_rise;
    assign w_write    = w_latch && w_row_ok;
    assign w_row_bad  = w_latch && !w_row_ok;
    assign w_len_bad  = w_latch && (r_bit_cnt != LP_LEN);
    assign w_complete = &r_mask;
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_HUNT;
        else       r_state <= w_state_next;
    end
    // the first latch seen while hunting marks a word boundary; three bad
    // row selects in a row mean alignment is lost
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_HUNT && w_stcp_rise) w_state_next = ST_ACTIVE;
        if (w_row_bad && r_err_cnt == 2'd2)   w_state_next = ST_HUNT;
        w_mask_next = (w_complete || w_state_next == ST_HUNT) ? '0 : r_mask;
        if (w_write) w_mask_next[w_row_enc] = 1'b1;
    end
    // shift register: the latch reads the pre-update sreg/bit_cnt, so a
    // coincident shift still lands and is counted toward the next word
    always_ff @(posedge clk) begin
        if (reset || !w_s[3]) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_shcp_rise) r_sreg <= {r_sreg[CHAIN_BITS-2:0], w_s[2]};
            r_bit_cnt <= w_stcp_rise ? 5'(w_shcp_rise) :
                         (w_shcp_rise && r_bit_cnt != 5'd31) ? r_bit_cnt + 5'd1 : r_bit_cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            row_data    <= '0;
            row_idx     <= '0;
            row_strobe  <= 1'b0;
            frame       <= '0;
            frame_valid <= 1'b0;
            display_on  <= 1'b0;
            len_err     <= 1'b0;
            row_err     <= 1'b0;
            r_buf       <= '0;
            r_mask      <= '0;
            r_err_cnt   <= '0;
        end else begin
            display_on  <= ~w_s[4];
            row_strobe  <= w_write;
            frame_valid <= w_complete;
            r_mask      <= w_mask_next;
            r_err_cnt   <= (w_state_next == ST_HUNT || w_write) ? 2'd0 :
                           w_row_bad ? r_err_cnt + 2'd1 : r_err_cnt;
            if (w_len_bad) len_err <= 1'b1;
            if (w_row_bad) row_err <= 1'b1;
            if (w_write) begin
                row_data <= r_sreg;
                row_idx  <= w_row_enc;
                r_buf[w_row_enc*CHAIN_BITS +: CHAIN_BITS] <= r_sreg;
            end
            if (w_complete) frame <= r_buf;
        end
    end
    assign locked = (r_state == ST_ACTIVE);
endmodule

// File: tb/tb_matrix_shift_receiver.sv
// tb_matrix_shift_receiver: scoreboard bench for matrix_shift_receiver
module tb_matrix_shift_receiver;
    logic         clk = 1'b0;
    logic         reset, shcp, stcp, ds, mr_n, oe_n;
    logic [7:0]   rows_in;
    logic [23:0]  row_data;
    logic [2:0]   row_idx;
    logic         row_strobe, frame_valid, display_on, len_err, row_err, locked;
    logic [191:0] frame;

    typedef struct {
        logic [23:0] d;
        logic [2:0]  idx;
    } row_t;

    row_t         q_row[$];
    logic [191:0] q_frame[$];
    logic [191:0] exp_frame;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           last_strobe = -10;

    matrix_shift_receiver dut (
        .clk(clk), .reset(reset), .shcp(shcp), .stcp(stcp), .ds(ds),
        .mr_n(mr_n), .oe_n(oe_n), .rows_in(rows_in),
        .row_data(row_data), .row_idx(row_idx), .row_strobe(row_strobe),
        .frame(frame), .frame_valid(frame_valid), .display_on(display_on),
        .len_err(len_err), .row_err(row_err), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        ds = b;
        tick(4);
        shcp = 1'b1;
        tick(4);
        shcp = 1'b0;
        tick(4);
    endtask

    task automatic shift_word(input logic [23:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(data[i]);
    endtask

    task automatic latch();
        stcp = 1'b1;
        tick(4);
        stcp = 1'b0;
        tick(4);
    endtask

    task automatic send(input logic [23:0] data, input int n, input logic [7:0] rows);
        rows_in = rows;
        shift_word(data, n);
        latch();
    endtask

    task automatic expect_row(input logic [23:0] d, input logic [2:0] idx);
        row_t e;
        e.d   = d;
        e.idx = idx;
        q_row.push_back(e);
    endtask

    // monitor: pops expectations whenever the DUT presents a row or a frame
    always @(negedge clk) begin
        if (!reset) begin
            if (row_strobe) begin
                last_strobe = cyc;
                if (q_row.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL row_unexpected: got row %0h idx %0d with nothing expected", row_data, row_idx);
                end else begin
                    row_t e;
                    e = q_row.pop_front();
                    chk("row_data", 192'(row_data), 192'(e.d));
                    chk("row_idx", 192'(row_idx), 192'(e.idx));
                end
            end
            if (frame_valid) begin
                chk("frame_delay", 192'(cyc), 192'(last_strobe + 1));
                if (q_frame.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got frame %0h with nothing expected", frame);
                end else begin
                    chk("frame", frame, q_frame.pop_front());
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; shcp = 1'b0; stcp = 1'b0; ds = 1'b0;
        mr_n = 1'b1; oe_n = 1'b1; rows_in = 8'h00;
        exp_frame = '0;
        tick(3);
        chk("rst_row_data", 192'(row_data), 192'(0));
        chk("rst_row_idx", 192'(row_idx), 192'(0));
        chk("rst_frame", frame, 192'(0));
        chk("rst_locked", 192'(locked), 192'(0));
        chk("rst_errs", 192'({len_err, row_err, row_strobe, frame_valid}), 192'(0));
        chk("rst_display_on", 192'(display_on), 192'(0));
        reset = 1'b0;
        tick(2);
        oe_n = 1'b0;
        tick(6);
        chk("display_on", 192'(display_on), 192'(1));

        // align: dummy latch then first row
        chk("hunt_locked", 192'(locked), 192'(0));
        latch();
        chk("dummy_locked", 192'(locked), 192'(1));
        expect_row(24'hFF00AA, 3'd0);
        send(24'hFF00AA, 24, 8'h01);
        chk("t1_locked", 192'(locked), 192'(1));
        chk("t1_len_err", 192'(len_err), 192'(0));

        // full frame, row r = 1<<r
        for (int r = 0; r < 8; r++) exp_frame[r*24 +: 24] = 24'h000001 << r;
        q_frame.push_back(exp_frame);
        for (int r = 0; r < 8; r++) begin
            expect_row(24'h000001 << r, 3'(r));
            send(24'h000001 << r, 24, 8'h01 << r);
        end
        tick(2);
        chk("t2_frame_hold", frame, exp_frame);
        chk("t2_len_err", 192'(len_err), 192'(0));
        chk("t2_row_err", 192'(row_err), 192'(0));

        // mr_n clear discards a partial word and its bit count
        rows_in = 8'h10;
        shift_word(24'hFFFFFF, 12);
        mr_n = 1'b0;
        tick(6);
        mr_n = 1'b1;
        tick(6);
        expect_row(24'h123456, 3'd4);
        send(24'h123456, 24, 8'h10);
        chk("mr_len_err", 192'(len_err), 192'(0));

        // coincident shcp/stcp: latch old word, the shifted bit starts the next
        rows_in = 8'h20;
        expect_row(24'h0F0F0F, 3'd5);
        shift_word(24'h0F0F0F, 24);
        ds = 1'b1;
        tick(4);
        shcp = 1'b1;
        stcp = 1'b1;
        tick(4);
        shcp = 1'b0;
        stcp = 1'b0;
        tick(4);
        chk("coinc_len_err", 192'(len_err), 192'(0));
        expect_row(24'h800000, 3'd6);
        send(24'h000000, 23, 8'h40);
        chk("coinc_next_len_err", 192'(len_err), 192'(0));

        // short word: flagged but written (top bit is the leftover 0 of 0x800000)
        expect_row(24'h555555, 3'd2);
        send(24'h555555, 23, 8'h04);
        chk("short_len_err", 192'(len_err), 192'(1));
        chk("short_row_err", 192'(row_err), 192'(0));
        expect_row(24'hABCDEF, 3'd2);
        send(24'hABCDEF, 24, 8'h04);
        chk("sticky_len_err", 192'(len_err), 192'(1));

        // bad row selects: three in a row drop lock
        send(24'h111111, 24, 8'h03);
        chk("rowerr_flag", 192'(row_err), 192'(1));
        chk("rowerr1_locked", 192'(locked), 192'(1));
        send(24'h111111, 24, 8'h03);
        chk("rowerr2_locked", 192'(locked), 192'(1));
        send(24'h111111, 24, 8'h03);
        chk("rowerr3_locked", 192'(locked), 192'(0));
        chk("rowerr_frame_kept", frame, exp_frame);
        rows_in = 8'h01;
        latch();
        chk("relock", 192'(locked), 192'(1));

        // reset mid-frame
        for (int r = 0; r < 4; r++) begin
            expect_row(24'h100000 * (r + 1), 3'(r));
            send(24'h100000 * (r + 1), 24, 8'h01 << r);
        end
        reset = 1'b1;
        tick(2);
        chk("midrst_frame", frame, 192'(0));
        chk("midrst_locked", 192'(locked), 192'(0));
        chk("midrst_row_data", 192'(row_data), 192'(0));
        chk("midrst_errs", 192'({len_err, row_err}), 192'(0));
        reset = 1'b0;
        tick(4);

        chk("rows_left", 192'(q_row.size()), 192'(0));
        chk("frames_left", 192'(q_frame.size()), 192'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
